rvsteel_reset_sequencer: RTL

RVSTEEL_RESET_SEQUENCER -- requirements
Module: rvsteel_reset_sequencer

---
 rtl/rvsteel_board_pkg.sv | 20 ++
 rtl/rvsteel_reset_sequencer_if.sv | 27 ++
 rtl/rvsteel_button_debouncer.sv | 50 +++++
 rtl/rvsteel_reset_sequencer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/rvsteel_board_pkg.sv
// Shared definitions for the rvsteel board reset sequencer: FSM state type,
// default parameter values and a counter-width helper.
package rvsteel_board_pkg;

  // 10 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES   = 500000;
  localparam int DEFAULT_RESET_HOLD_CYCLES = 16;

  typedef enum logic [1:0] {
    HOLD         = 2'd0,
    RUN          = 2'd1,
    WAIT_RELEASE = 2'd2
  } seq_state_t;

  // Width of a counter that must reach n-1 without wrapping; never below 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rvsteel_reset_sequencer_if.sv
// Board-side signal bundle of the reset sequencer: raw push-buttons in,
// core reset/halt and ready out. The sequencer uses the slave modport.
interface rvsteel_reset_sequencer_if;

  logic reset_button;
  logic halt_button;
  logic core_reset;
  logic core_halt;
  logic ready;

  modport master (
    output reset_button,
    output halt_button,
    input  core_reset,
    input  core_halt,
    input  ready
  );

  modport slave (
    input  reset_button,
    input  halt_button,
    output core_reset,
    output core_halt,
    output ready
  );

endinterface

// File: rtl/rvsteel_button_debouncer.sv
// Push-button conditioner: 2-flop synchronizer followed by a debounce counter.
// The debounced level flips only after the synchronized input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles.
module rvsteel_button_debouncer
  import rvsteel_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_out;
  logic [CNT_W-1:0] cnt;

  // Bring the raw button into the clock domain before anything looks at it.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of its neighbours; '=' here would collapse the 2-flop chain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;
    end
  end

  // Count consecutive disagreement cycles; accept the new level on the last one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_out == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= ~level;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rvsteel_reset_sequencer.sv
// rvsteel board reset sequencer. Debounces the reset and halt push-buttons
// and sequences the core reset: HOLD (fixed-width reset pulse) -> RUN ->
// WAIT_RELEASE (button held) -> HOLD. core_halt is only ever high in RUN.
// Optional feature macro HALT_TOGGLE_EN: when defined, each debounced halt
// press in RUN toggles a halt latch instead of core_halt following the level.
module rvsteel_reset_sequencer
  import rvsteel_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int RESET_HOLD_CYCLES = DEFAULT_RESET_HOLD_CYCLES
) (
  input logic                            clock,
  input logic                            reset,
  rvsteel_reset_sequencer_if.slave       board
);

  localparam int                HOLD_W    = cnt_width(RESET_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  // Reject configurations the debouncer and hold counter cannot honour.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("rvsteel_reset_sequencer: DEBOUNCE_CYCLES must be >= 2");
  end
  if (RESET_HOLD_CYCLES < 1) begin : g_bad_hold
    $error("rvsteel_reset_sequencer: RESET_HOLD_CYCLES must be >= 1");
  end

  seq_state_t        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              deb_reset;
  logic              deb_halt;
  logic              core_reset_q;
  logic              core_halt_q;
  logic              ready_q;

  rvsteel_button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_reset_debouncer (
    .clock (clock),
    .reset (reset),
    .raw   (board.reset_button),
    .level (deb_reset)
  );

  rvsteel_button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_halt_debouncer (
    .clock (clock),
    .reset (reset),
    .raw   (board.halt_button),
    .level (deb_halt)
  );

`ifdef HALT_TOGGLE_EN
  logic deb_halt_q;

  // Previous debounced halt level, used to spot a fresh press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_halt_q <= 1'b0;
    end else begin
      deb_halt_q <= deb_halt;
    end
  end
`endif

  // Sequencer FSM with registered outputs; a reset press in RUN takes
  // priority over any halt activity on the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= HOLD;
      hold_cnt     <= '0;
      core_reset_q <= 1'b1;
      core_halt_q  <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state        <= RUN;
            hold_cnt     <= '0;
            core_reset_q <= 1'b0;
            ready_q      <= 1'b1;
            core_halt_q  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          if (deb_reset) begin
            state        <= WAIT_RELEASE;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
            core_halt_q  <= 1'b0;
          end else begin
`ifdef HALT_TOGGLE_EN
            if (deb_halt && !deb_halt_q) begin
              core_halt_q <= ~core_halt_q;
            end
`else
            core_halt_q <= deb_halt;
`endif
          end
        end
        WAIT_RELEASE: begin
          if (!deb_reset) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        // NOTE: the unused encoding recovers to a full reset sequence rather
        // than leaving the core running from an undefined state.
        default: begin
          state        <= HOLD;
          hold_cnt     <= '0;
          core_reset_q <= 1'b1;
          core_halt_q  <= 1'b0;
          ready_q      <= 1'b0;
        end
      endcase
    end
  end

  assign board.core_reset = core_reset_q;
  assign board.core_halt  = core_halt_q;
  assign board.ready      = ready_q;

endmodule
